// File: rtl/rtc_edit_ctrl_if.sv
// RTC register write channel between the edit controller and the RTC write
// sequencer.
//   wr_req   request, held until acknowledged
//   wr_addr  RTC register address, stable while wr_req is high
//   wr_data  BCD register value, stable while wr_req is high
//   wr_ack   one-cycle acknowledge from the sequencer
// master: controller side, slave: sequencer side.
interface rtc_edit_ctrl_if;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;

  modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
  modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/rtc_edit_ctrl.sv
// RTC configuration controller.
// Captures the current time/timer into an edit buffer when configurate rises,
// lets the arrow pulses move a cursor and adjust sec/min/hour in BCD, and on a
// write toggle issues three handshaked register writes (sec, min, hour).
// Ports:
//   clk, reset (async, active low)
//   configurate  level; rise enters edit, fall aborts
//   write        toggle; any change requests a commit
//   clock_timer  0 = clock registers, 1 = timer registers
//   T24_12       0 = 24 h, 1 = 12 h hour range
//   arriba/abajo/izquierda/derecha  one-cycle arrow pulses
//   cur_sec/min/hour  current BCD values of the selected set
//   edit_active, busy, cursor, edit_sec/min/hour, done  status / edit buffer
//   wr           write channel (master side)
module rtc_edit_ctrl #(
  parameter logic [7:0] ADDR_CLK_SEC = 8'h21,
  parameter logic [7:0] ADDR_TMR_SEC = 8'h41
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       configurate,
  input  logic       write,
  input  logic       clock_timer,
  input  logic       T24_12,
  input  logic       arriba,
  input  logic       abajo,
  input  logic       izquierda,
  input  logic       derecha,
  input  logic [7:0] cur_sec,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_hour,
  output logic       edit_active,
  output logic       busy,
  output logic [1:0] cursor,
  output logic [7:0] edit_sec,
  output logic [7:0] edit_min,
  output logic [7:0] edit_hour,
  output logic       done,
  rtc_edit_ctrl_if.master wr
);

  typedef enum logic [2:0] {IDLE, EDIT, COMMIT, GAP, DONE} state_t;

  state_t     state, state_nxt;
  logic [1:0] k, k_nxt;           // field being written: 0 sec, 1 min, 2 hour
  logic       sel_tmr, sel_nxt;   // register set latched at commit start
  logic       cfg_q, wr_q, t12_q, ct_q;
  logic       cfg_rise, cfg_fall, wr_tgl, ct_chg, t12_chg;
  logic       edit_active_d, busy_d, done_d, wr_req_d;
  logic [7:0] wr_addr_d, wr_data_d, fld;
  logic [6:0] hr_lo, hr_hi;

  function automatic logic [6:0] bcd2bin(input logic [7:0] b);
    return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  // +/-1 with wrap inside [lo, hi]
  function automatic logic [7:0] step(input logic [7:0] f, input logic up,
                                      input logic [6:0] lo, input logic [6:0] hi);
    logic [6:0] v;
    v = bcd2bin(f);
    if (up) v = (v >= hi) ? lo : v + 7'd1;
    else    v = (v <= lo) ? hi : v - 7'd1;
    return bin2bcd(v);
  endfunction

  // Entry value is saturated into the active hour range.
  function automatic logic [7:0] clamp_hour(input logic [7:0] h, input logic t12);
    logic [6:0] v;
    v = bcd2bin(h);
    if (t12) begin
      if (v < 7'd1)       v = 7'd1;
      else if (v > 7'd12) v = 7'd12;
    end else if (v > 7'd23) begin
      v = 7'd23;
    end
    return bin2bcd(v);
  endfunction

  function automatic logic [7:0] to_12h(input logic [7:0] h);
    logic [6:0] v;
    v = bcd2bin(h);
    if (v == 7'd0)       v = 7'd12;
    else if (v >= 7'd13) v = v - 7'd12;
    return bin2bcd(v);
  endfunction

  assign cfg_rise = configurate & ~cfg_q;
  assign cfg_fall = ~configurate & cfg_q;
  assign wr_tgl   = write ^ wr_q;
  assign ct_chg   = clock_timer ^ ct_q;
  assign t12_chg  = T24_12 ^ t12_q;
  assign hr_lo    = T24_12 ? 7'd1 : 7'd0;
  assign hr_hi    = T24_12 ? 7'd12 : 7'd23;

  // Edge-detect history, tracked in every state so that edges arriving while
  // busy are consumed and cannot fire later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_q <= 1'b0;
      wr_q  <= 1'b0;
      t12_q <= 1'b0;
      ct_q  <= 1'b0;
    end else begin
      cfg_q <= configurate;
      wr_q  <= write;
      t12_q <= T24_12;
      ct_q  <= clock_timer;
    end
  end

  // State register plus registered output decodes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      k           <= 2'd0;
      sel_tmr     <= 1'b0;
      edit_active <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wr.wr_req   <= 1'b0;
      wr.wr_addr  <= 8'h00;
      wr.wr_data  <= 8'h00;
    end else begin
      state       <= state_nxt;
      k           <= k_nxt;
      sel_tmr     <= sel_nxt;
      edit_active <= edit_active_d;
      busy        <= busy_d;
      done        <= done_d;
      wr.wr_req   <= wr_req_d;
      wr.wr_addr  <= wr_addr_d;
      wr.wr_data  <= wr_data_d;
    end
  end

  // Next state
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    sel_nxt   = sel_tmr;
    case (state)
      IDLE:   if (cfg_rise) state_nxt = EDIT;
      EDIT: begin
        if (cfg_fall || ct_chg) begin
          state_nxt = IDLE;
        end else if (wr_tgl) begin
          state_nxt = COMMIT;
          k_nxt     = 2'd0;
          sel_nxt   = clock_timer;
        end
      end
      COMMIT: if (wr.wr_ack) state_nxt = (k == 2'd2) ? DONE : GAP;
      GAP: begin
        state_nxt = COMMIT;
        k_nxt     = k + 2'd1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs, decoded from the next state so they register alongside it
  always_comb begin
    case (k_nxt)
      2'd0:    fld = edit_sec;
      2'd1:    fld = edit_min;
      default: fld = edit_hour;
    endcase
    edit_active_d = (state_nxt == EDIT);
    busy_d        = (state_nxt == COMMIT) || (state_nxt == GAP);
    done_d        = (state_nxt == DONE);
    wr_req_d      = (state_nxt == COMMIT);
    wr_addr_d     = 8'h00;
    wr_data_d     = 8'h00;
    if (wr_req_d) begin
      wr_addr_d = (sel_nxt ? ADDR_TMR_SEC : ADDR_CLK_SEC) + {6'd0, k_nxt};
      wr_data_d = fld;
    end
  end

  // Edit buffer and cursor. A range-mode change takes the whole cycle; arrows
  // arriving with it are dropped so the hour is never stepped in a stale range.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cursor    <= 2'd0;
      edit_sec  <= 8'h00;
      edit_min  <= 8'h00;
      edit_hour <= 8'h00;
    end else if (state == IDLE && state_nxt == EDIT) begin
      cursor    <= 2'd0;
      edit_sec  <= cur_sec;
      edit_min  <= cur_min;
      edit_hour <= clamp_hour(cur_hour, T24_12);
    end else if (state != IDLE && state_nxt == IDLE) begin
      cursor    <= 2'd0;
      edit_sec  <= 8'h00;
      edit_min  <= 8'h00;
      edit_hour <= 8'h00;
    end else if (state == EDIT && state_nxt == EDIT) begin
      if (t12_chg) begin
        if (T24_12) edit_hour <= to_12h(edit_hour);
      end else if (arriba || abajo) begin
        case (cursor)
          2'd0:    edit_sec  <= step(edit_sec, arriba, 7'd0, 7'd59);
          2'd1:    edit_min  <= step(edit_min, arriba, 7'd0, 7'd59);
          default: edit_hour <= step(edit_hour, arriba, hr_lo, hr_hi);
        endcase
      end else if (izquierda) begin
        cursor <= (cursor == 2'd0) ? 2'd2 : cursor - 2'd1;
      end else if (derecha) begin
        cursor <= (cursor >= 2'd2) ? 2'd0 : cursor + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_rtc_edit_ctrl.sv
module tb_rtc_edit_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, configurate, write, clock_timer, T24_12;
  logic       arriba, abajo, izquierda, derecha;
  logic [7:0] cur_sec, cur_min, cur_hour;
  logic       edit_active, busy, done;
  logic [1:0] cursor;
  logic [7:0] edit_sec, edit_min, edit_hour;

  rtc_edit_ctrl_if wr_if();

  rtc_edit_ctrl dut (
    .clk(clk), .reset(reset), .configurate(configurate), .write(write),
    .clock_timer(clock_timer), .T24_12(T24_12),
    .arriba(arriba), .abajo(abajo), .izquierda(izquierda), .derecha(derecha),
    .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
    .edit_active(edit_active), .busy(busy), .cursor(cursor),
    .edit_sec(edit_sec), .edit_min(edit_min), .edit_hour(edit_hour),
    .done(done), .wr(wr_if)
  );

  // Reference model: plain integers, edit buffer visible only in edit mode.
  int m_sec, m_min, m_hour, m_cur;
  bit m_edit;
  int n_chk = 0, n_pass = 0;

  function automatic logic [7:0] bcd(int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [26:0] exp_vec();
    return {m_edit, 2'(m_cur), bcd(m_sec), bcd(m_min), bcd(m_hour)};
  endfunction

  function automatic logic [26:0] dut_vec();
    return {edit_active, cursor, edit_sec, edit_min, edit_hour};
  endfunction

  task automatic m_clear();
    m_sec = 0; m_min = 0; m_hour = 0; m_cur = 0; m_edit = 0;
  endtask

  task automatic m_enter(int s, int m, int h);
    m_sec = s; m_min = m; m_cur = 0; m_edit = 1;
    if (T24_12) m_hour = (h < 1) ? 1 : ((h > 12) ? 12 : h);
    else        m_hour = (h > 23) ? 23 : h;
  endtask

  task automatic m_arrow(logic [3:0] ar);  // {arriba, abajo, izquierda, derecha}
    if (ar[3] || ar[2]) begin
      case (m_cur)
        0: m_sec = ar[3] ? (m_sec + 1) % 60 : (m_sec + 59) % 60;
        1: m_min = ar[3] ? (m_min + 1) % 60 : (m_min + 59) % 60;
        default:
          if (T24_12) m_hour = ar[3] ? (m_hour % 12) + 1 : ((m_hour == 1) ? 12 : m_hour - 1);
          else        m_hour = ar[3] ? (m_hour + 1) % 24 : (m_hour + 23) % 24;
      endcase
    end else if (ar[1]) m_cur = (m_cur + 2) % 3;
    else if (ar[0])     m_cur = (m_cur + 1) % 3;
  endtask

  task automatic m_mode_change();
    if (T24_12) m_hour = (m_hour == 0) ? 12 : ((m_hour > 12) ? m_hour - 12 : m_hour);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_enter(int s, int m, int h);
    if (configurate) begin
      configurate = 1'b0; tick(); m_clear();
    end
    cur_sec = bcd(s); cur_min = bcd(m); cur_hour = bcd(h);
    configurate = 1'b1;
    tick();
    m_enter(s, m, h);
  endtask

  task automatic pulse(logic [3:0] ar);
    {arriba, abajo, izquierda, derecha} = ar;
    tick();
    {arriba, abajo, izquierda, derecha} = 4'b0;
    m_arrow(ar);
  endtask

  task automatic set_mode(logic t12);
    T24_12 = t12;
    tick();
    m_mode_change();
  endtask

  task automatic test_reset();
    reset = 1'b0; configurate = 0; write = 0; clock_timer = 0; T24_12 = 0;
    {arriba, abajo, izquierda, derecha} = 4'b0;
    cur_sec = 0; cur_min = 0; cur_hour = 0; wr_if.wr_ack = 0;
    m_clear();
    tick(); tick();
    n_chk++;
    if ({dut_vec(), busy, done, wr_if.wr_req, wr_if.wr_addr, wr_if.wr_data} !== 46'd0)
      $display("FAIL reset_outputs got vec=%h busy=%b done=%b req=%b addr=%h data=%h want all 0",
               dut_vec(), busy, done, wr_if.wr_req, wr_if.wr_addr, wr_if.wr_data);
    else n_pass++;
    reset = 1'b1;
    tick();
    n_chk++;
    if ({dut_vec(), busy, done, wr_if.wr_req} !== 30'd0)
      $display("FAIL reset_release got vec=%h busy=%b done=%b req=%b want 0", dut_vec(), busy, done, wr_if.wr_req);
    else n_pass++;
  endtask

  task automatic test_entry();
    do_enter(45, 30, 14);
    n_chk++;
    if (dut_vec() !== exp_vec() || dut_vec() !== {1'b1, 2'd0, 8'h45, 8'h30, 8'h14})
      $display("FAIL entry got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_enter(59, 30, 14);
    pulse(4'b1000);
    n_chk++;
    if (edit_sec !== 8'h00 || dut_vec() !== exp_vec())
      $display("FAIL sec_wrap_up got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
    pulse(4'b0100);
    n_chk++;
    if (edit_sec !== 8'h59 || dut_vec() !== exp_vec())
      $display("FAIL sec_wrap_down got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_hour_wrap();
    do_enter(10, 10, 23);
    pulse(4'b0001); pulse(4'b0001);
    n_chk++;
    if (cursor !== 2'd2) $display("FAIL cursor_right got %0d want 2", cursor);
    else n_pass++;
    pulse(4'b1000);
    n_chk++;
    if (edit_hour !== 8'h00 || dut_vec() !== exp_vec())
      $display("FAIL hour24_wrap got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
    set_mode(1'b1);
    n_chk++;
    if (edit_hour !== 8'h12 || dut_vec() !== exp_vec())
      $display("FAIL hour_00_to_12 got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
    pulse(4'b1000);
    n_chk++;
    if (edit_hour !== 8'h01 || dut_vec() !== exp_vec())
      $display("FAIL hour12_wrap got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
    set_mode(1'b0);
    n_chk++;
    if (dut_vec() !== exp_vec()) $display("FAIL mode_12_to_24 got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_mode_convert();
    do_enter(0, 0, 14);
    set_mode(1'b1);
    n_chk++;
    if (edit_hour !== 8'h02 || dut_vec() !== exp_vec())
      $display("FAIL mode_24_to_12 got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
    pulse(4'b0010);
    n_chk++;
    if (cursor !== 2'd2 || dut_vec() !== exp_vec())
      $display("FAIL cursor_left_wrap got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
    set_mode(1'b0);
  endtask

  task automatic test_clamp();
    configurate = 1'b0; tick(); m_clear();
    T24_12 = 1'b1; tick();
    do_enter(5, 6, 18);
    n_chk++;
    if (edit_hour !== 8'h12 || dut_vec() !== exp_vec()) $display("FAIL clamp12_high got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
    do_enter(5, 6, 0);
    n_chk++;
    if (edit_hour !== 8'h01 || dut_vec() !== exp_vec()) $display("FAIL clamp12_low got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
    configurate = 1'b0; tick(); m_clear();
    T24_12 = 1'b0; tick();
    do_enter(5, 6, 27);
    n_chk++;
    if (edit_hour !== 8'h23 || dut_vec() !== exp_vec()) $display("FAIL clamp24 got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic rand_edit(int n);
    for (int i = 0; i < n; i++) begin
      bit tg;
      logic [3:0] ar;
      tg = ($urandom_range(0, 7) == 0);
      ar = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) ar = 4'b0;
      if (tg) begin
        T24_12 = ~T24_12;
        {arriba, abajo, izquierda, derecha} = ar;
        tick();
        {arriba, abajo, izquierda, derecha} = 4'b0;
        m_mode_change();
      end else begin
        pulse(ar);
      end
      n_chk++;
      if (dut_vec() !== exp_vec())
        $display("FAIL random_edit step=%0d ar=%b t12=%b got %h want %h", i, ar, T24_12, dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_random_edit();
    do_enter($urandom_range(0, 59), $urandom_range(0, 59), $urandom_range(0, 23));
    rand_edit(200);
  endtask

  task automatic test_ack_ignored();
    configurate = 1'b0; tick(); m_clear();
    wr_if.wr_ack = 1'b1; tick(); wr_if.wr_ack = 1'b0; tick();
    n_chk++;
    if ({wr_if.wr_req, busy, done} !== 3'b000 || dut_vec() !== exp_vec())
      $display("FAIL ack_in_idle got req=%b busy=%b done=%b", wr_if.wr_req, busy, done);
    else n_pass++;
    do_enter(12, 34, 5);
    wr_if.wr_ack = 1'b1; tick(); wr_if.wr_ack = 1'b0; tick();
    n_chk++;
    if ({wr_if.wr_req, busy, done} !== 3'b000 || dut_vec() !== exp_vec())
      $display("FAIL ack_in_edit got req=%b vec=%h want vec=%h", wr_if.wr_req, dut_vec(), exp_vec());
    else n_pass++;
  endtask

  // Toggle write (with a random arrow in the same cycle) and run the three writes.
  task automatic run_commit(int d0, int d1, int d2, bit stir);
    int dl[3];
    logic [7:0] base;
    logic [7:0] fld[3];
    dl = '{d0, d1, d2};
    base = clock_timer ? 8'h41 : 8'h21;
    fld = '{bcd(m_sec), bcd(m_min), bcd(m_hour)};
    write = ~write;
    arriba = 1'($urandom_range(0, 1));
    tick();
    arriba = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c <= dl[k]; c++) begin
        if (c == dl[k]) wr_if.wr_ack = 1'b1;
        else if (stir) begin
          configurate = 1'($urandom_range(0, 1));
          T24_12 = 1'($urandom_range(0, 1));
          clock_timer = 1'($urandom_range(0, 1));
        end
        n_chk++;
        if ({wr_if.wr_req, busy, done, wr_if.wr_addr, wr_if.wr_data} !== {3'b110, base + 8'(k), fld[k]})
          $display("FAIL commit_write k=%0d c=%0d got req=%b busy=%b addr=%h data=%h want addr=%h data=%h",
                   k, c, wr_if.wr_req, busy, wr_if.wr_addr, wr_if.wr_data, base + 8'(k), fld[k]);
        else n_pass++;
        tick();
      end
      wr_if.wr_ack = 1'b0;
      if (k < 2) begin
        n_chk++;
        if ({wr_if.wr_req, busy, done} !== 3'b010)
          $display("FAIL commit_gap k=%0d got req=%b busy=%b done=%b want 0/1/0", k, wr_if.wr_req, busy, done);
        else n_pass++;
        tick();
      end else begin
        n_chk++;
        if ({wr_if.wr_req, busy, done, edit_active} !== 4'b0010)
          $display("FAIL commit_done got req=%b busy=%b done=%b edit=%b want 0/0/1/0",
                   wr_if.wr_req, busy, done, edit_active);
        else n_pass++;
      end
    end
    tick();
    m_clear();
    n_chk++;
    if ({wr_if.wr_req, busy, done} !== 3'b000 || dut_vec() !== exp_vec())
      $display("FAIL commit_idle got req=%b busy=%b done=%b vec=%h want idle", wr_if.wr_req, busy, done, dut_vec());
    else n_pass++;
  endtask

  task automatic test_commit();
    configurate = 1'b0; tick(); m_clear();
    clock_timer = 1'b1; tick();
    do_enter(10, 20, 8);
    run_commit(0, 3, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      configurate = 1'b0; tick(); m_clear();
      clock_timer = 1'($urandom_range(0, 1));
      tick();
      do_enter($urandom_range(0, 59), $urandom_range(0, 59), $urandom_range(0, 29));
      rand_edit(12);
      run_commit($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), 1'b1);
    end
  endtask

  task automatic test_abort();
    do_enter(1, 2, 3);
    pulse(4'b1000);
    configurate = 1'b0;
    tick();
    m_clear();
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (wr_if.wr_req !== 1'b0 || busy !== 1'b0 || dut_vec() !== exp_vec())
        $display("FAIL abort_cfg cyc=%0d got req=%b vec=%h want 0", i, wr_if.wr_req, dut_vec());
      else n_pass++;
      tick();
    end
    do_enter(4, 5, 6);
    clock_timer = ~clock_timer;
    tick();
    m_clear();
    n_chk++;
    if (wr_if.wr_req !== 1'b0 || dut_vec() !== exp_vec())
      $display("FAIL abort_ct got req=%b vec=%h want 0", wr_if.wr_req, dut_vec());
    else n_pass++;
  endtask

  task automatic test_reset_mid_commit();
    do_enter(7, 8, 9);
    write = ~write;
    tick();
    n_chk++;
    if (wr_if.wr_req !== 1'b1) $display("FAIL pre_reset_req got %b want 1", wr_if.wr_req);
    else n_pass++;
    reset = 1'b0;
    #1;
    m_clear();
    n_chk++;
    if ({wr_if.wr_req, busy, done} !== 3'b000 || dut_vec() !== exp_vec())
      $display("FAIL reset_mid_commit got req=%b busy=%b vec=%h want 0", wr_if.wr_req, busy, dut_vec());
    else n_pass++;
    configurate = 1'b0;
    tick();
    reset = 1'b1;
    tick(); tick();
    n_chk++;
    if ({wr_if.wr_req, busy, done} !== 3'b000 || dut_vec() !== exp_vec())
      $display("FAIL after_reset got req=%b busy=%b vec=%h want idle", wr_if.wr_req, busy, dut_vec());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_entry();
    test_wrap();
    test_hour_wrap();
    test_mode_convert();
    test_clamp();
    test_random_edit();
    test_ack_ignored();
    test_commit();
    test_back_to_back();
    test_abort();
    test_reset_mid_commit();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
